// File: rtl/mac_sequencer.sv
// Sequencer for a 3-cycle MAC: fetches 3 data/weight words per result from sync-read
// memories, keeps the MAC accumulator aligned, and holds each sum in a valid/ready output slot.
module mac_sequencer #(
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_out,
  input  logic              shared_data,
  output logic [ADDR_W-1:0] data_addr,
  output logic [ADDR_W-1:0] weight_addr,
  input  logic [23:0]       data_rdata,
  input  logic [23:0]       weight_rdata,
  output logic [23:0]       mac_data,
  output logic [23:0]       mac_weight,
  output logic              mac_reset,
  input  logic [19:0]       mac_result,
  output logic [19:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_FEED0, S_FEED1, S_FEED2, S_CAPT, S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  k_q, k_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic              shared_q, shared_d;
  logic [19:0]       out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              done_q, done_d;

  logic              slot_free;
  logic              issue;
  logic              feed;
  logic              mac_clear;
  logic [ADDR_W-1:0] word;
  logic [ADDR_W-1:0] base;

  assign slot_free = !out_valid_q || out_ready;
  // Group base 3k built from shifts so the product stays ADDR_W wide.
  assign base      = (ADDR_W'(k_q) << 1) + ADDR_W'(k_q);

  // NOTE: this block describes state with a synchronous reset, so every register uses
  // non-blocking assignments; blocking ones would let later flops see same-cycle values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      num_q       <= '0;
      shared_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      num_q       <= num_d;
      shared_q    <= shared_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    num_d       = num_q;
    shared_d    = shared_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    issue       = 1'b0;
    feed        = 1'b0;
    mac_clear   = 1'b1;
    word        = '0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d    = num_out;
          shared_d = shared_data;
          k_d      = '0;
          state_d  = (num_out != '0) ? S_CLR : S_DRAIN;
        end
      end
      S_CLR: begin
        issue = 1'b1;
        // Entering FEED0 only with a free slot guarantees CAPT never overwrites a result.
        if (slot_free) state_d = S_FEED0;
      end
      S_FEED0: begin
        mac_clear = 1'b0;
        feed      = 1'b1;
        issue     = 1'b1;
        word      = ADDR_W'(1);
        state_d   = S_FEED1;
      end
      S_FEED1: begin
        mac_clear = 1'b0;
        feed      = 1'b1;
        issue     = 1'b1;
        word      = ADDR_W'(2);
        state_d   = S_FEED2;
      end
      S_FEED2: begin
        mac_clear = 1'b0;
        feed      = 1'b1;
        state_d   = S_CAPT;
      end
      S_CAPT: begin
        out_data_d  = mac_result;
        out_valid_d = 1'b1;
        if (k_q == num_q - CNT_W'(1)) begin
          state_d = S_DRAIN;
        end else begin
          k_d     = k_q + CNT_W'(1);
          state_d = S_CLR;
        end
      end
      S_DRAIN: begin
        if (slot_free) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign weight_addr = issue ? base + word : '0;
  assign data_addr   = issue ? (shared_q ? word : base + word) : '0;
  assign mac_data    = feed ? data_rdata   : '0;
  assign mac_weight  = feed ? weight_rdata : '0;
  assign mac_reset   = reset | mac_clear;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: memory and MAC models around the DUT, table-driven jobs,
// hand-written stall/reset/shared-data sequences, then randomized jobs against a sum model.
module tb_mac_sequencer;

  localparam int CNT_W  = 8;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [CNT_W-1:0]  num_out;
  logic              shared_data;
  logic [ADDR_W-1:0] data_addr, weight_addr;
  logic [23:0]       data_rdata, weight_rdata;
  logic [23:0]       mac_data, mac_weight;
  logic              mac_reset;
  logic [19:0]       mac_result;
  logic [19:0]       out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  mac_sequencer #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .num_out(num_out), .shared_data(shared_data),
    .data_addr(data_addr), .weight_addr(weight_addr),
    .data_rdata(data_rdata), .weight_rdata(weight_rdata),
    .mac_data(mac_data), .mac_weight(mac_weight), .mac_reset(mac_reset),
    .mac_result(mac_result), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [23:0] dmem [1024];
  logic [23:0] wmem [1024];
  logic [19:0] acc;

  function automatic int dot3(input logic [23:0] x, input logic [23:0] y);
    int s = 0;
    for (int l = 0; l < 3; l++) s += int'($signed(x[8*l +: 8])) * int'($signed(y[8*l +: 8]));
    return s;
  endfunction

  // Operand memories with one-cycle read latency, and a MAC that clears on mac_reset.
  always @(posedge clk) begin
    data_rdata   <= dmem[data_addr];
    weight_rdata <= wmem[weight_addr];
    if (mac_reset) acc <= '0;
    else           acc <= acc + 20'(dot3(mac_data, mac_weight));
  end
  assign mac_result = acc;

  // Reference: result k is the lane-wise dot product summed over its three words.
  function automatic int model(input int k, input bit sh);
    int s = 0;
    for (int j = 0; j < 3; j++) s += dot3(dmem[sh ? j : 3*k + j], wmem[3*k + j]);
    return s;
  endfunction

  int checks = 0;
  int errors = 0;
  int first_valid_cyc, done_cyc, busy_cycles, last_out;
  int da_log [64];
  int wa_log [64];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_const(input logic [23:0] dw, input logic [23:0] ww);
    for (int i = 0; i < 1024; i++) begin
      dmem[i] = dw;
      wmem[i] = ww;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 1024; i++) begin
      dmem[i] = 24'($urandom());
      wmem[i] = 24'($urandom());
    end
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low for 10 valid cycles, then high.
  task automatic run_job(input int n, input bit sh, input int mode);
    int exp_q[$];
    int c, hold, held;
    bit got_done;
    for (int k = 0; k < n; k++) exp_q.push_back(model(k, sh));
    first_valid_cyc = -1;
    done_cyc        = -1;
    busy_cycles     = 0;
    num_out     = CNT_W'(n);
    shared_data = sh;
    start       = 1'b1;
    out_ready   = (mode != 2);
    @(posedge clk); #1;
    start    = 1'b0;
    c        = 1;
    hold     = 0;
    held     = 0;
    got_done = 1'b0;
    while (!got_done && c < 3000) begin
      @(negedge clk);
      if (c < 64) begin
        da_log[c] = int'(data_addr);
        wa_log[c] = int'(weight_addr);
      end
      if (busy) busy_cycles++;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = c;
      if (mode == 2 && out_valid && hold < 10) begin
        if (hold == 0) held = int'($signed(out_data));
        else           check("stall out_data held", int'($signed(out_data)), held);
        check("stall data_addr", int'(data_addr), 3);
        check("stall mac_reset", int'(mac_reset), 1);
        hold++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected result", 1, 0);
        else begin
          last_out = int'($signed(out_data));
          check("result", last_out, exp_q.pop_front());
        end
      end
      if (done) begin
        got_done = 1'b1;
        done_cyc = c;
      end
      @(posedge clk); #1;
      c++;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (hold >= 10);
      endcase
    end
    if (!got_done) check("job timeout", 0, 1);
    check("results outstanding", exp_q.size(), 0);
    @(negedge clk);
    check("done single cycle", int'(done), 0);
    check("idle after done", int'(busy), 0);
  endtask

  typedef struct {
    int          n;
    bit          sh;
    logic [23:0] dw;
    logic [23:0] ww;
    int          exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int bad;
    vecs[0] = '{1, 1'b0, 24'h010101, 24'h020202, 18};
    vecs[1] = '{1, 1'b0, 24'h808080, 24'h7F7F7F, -146304};
    vecs[2] = '{2, 1'b0, 24'hFFFFFF, 24'h010101, -9};
    vecs[3] = '{1, 1'b0, 24'h7F7F7F, 24'h7F7F7F, 145161};
    vecs[4] = '{3, 1'b1, 24'h01FF80, 24'h020202, -768};
    vecs[5] = '{1, 1'b0, 24'h808080, 24'h808080, 147456};

    reset       = 1'b1;
    start       = 1'b0;
    num_out     = '0;
    shared_data = 1'b0;
    out_ready   = 1'b1;
    fill_const(24'h0, 24'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mac_reset during reset", int'(mac_reset), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset out_valid", int'(out_valid), 0);
    check("reset out_data", int'(out_data), 0);
    check("reset done", int'(done), 0);
    check("reset data_addr", int'(data_addr), 0);
    check("reset weight_addr", int'(weight_addr), 0);
    check("reset mac_data", int'(mac_data), 0);
    check("reset mac_weight", int'(mac_weight), 0);
    check("idle mac_reset", int'(mac_reset), 1);
    @(posedge clk); #1;

    // Uniform-memory vectors: known sums, latency and throughput with ready held high.
    foreach (vecs[i]) begin
      fill_const(vecs[i].dw, vecs[i].ww);
      run_job(vecs[i].n, vecs[i].sh, 0);
      check("vector out_data", last_out, vecs[i].exp);
      check("vector first valid cycle", first_valid_cyc, 6);
      check("vector done cycle", done_cyc, 5 * vecs[i].n + 2);
    end

    // Back-pressure: slot full holds out_data and parks the FSM in CLR for k=1.
    fill_random();
    run_job(3, 1'b0, 2);

    // Empty job: one busy cycle, done two cycles after start, no results.
    run_job(0, 1'b0, 0);
    check("empty job done cycle", done_cyc, 2);
    check("empty job busy cycles", busy_cycles, 1);
    check("empty job no valid", first_valid_cyc, -1);

    // Shared data words: data addresses repeat per group, weights advance.
    fill_random();
    run_job(2, 1'b1, 0);
    for (int i = 0; i < 3; i++) begin
      check("shared data_addr k0", da_log[1+i], i);
      check("shared data_addr k1", da_log[6+i], i);
      check("shared weight_addr k0", wa_log[1+i], i);
      check("shared weight_addr k1", wa_log[6+i], 3 + i);
    end

    // Reset in FEED1 aborts the job immediately with no result and no done.
    fill_random();
    num_out     = CNT_W'(2);
    shared_data = 1'b0;
    out_ready   = 1'b1;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort busy", int'(busy), 0);
    check("abort out_valid", int'(out_valid), 0);
    check("abort mac_reset", int'(mac_reset), 1);
    check("abort data_addr", int'(data_addr), 0);
    check("abort mac_data", int'(mac_data), 0);
    check("abort done", int'(done), 0);
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid || done || busy) bad++;
    end
    check("abort stays quiet", bad, 0);
    @(posedge clk); #1;
    run_job(2, 1'b0, 0);
    check("post-abort first valid cycle", first_valid_cyc, 6);

    // Randomized jobs with random back-pressure against the sum model.
    for (int t = 0; t < 25; t++) begin
      fill_random();
      run_job($urandom_range(0, 6), 1'($urandom_range(0, 1)), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
